// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over im_req/im_ready, holds them for retire, resolves next PC
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ready,
    input  logic [31:0]       im_rdata,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    input  logic              inst_accept,
    input  logic              is_branch,
    input  logic              branch_ne,
    input  logic              rt_ra_equal,
    input  logic              is_jump,
    input  logic [13:0]       imm_14bit,
    input  logic [23:0]       imm_24bit,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_pc,
    output logic              fetch_error
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERROR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_off;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;
    assign br_off  = {{(ADDR_W-14){imm_14bit[13]}}, imm_14bit} << 1;
    assign jmp_off = {{(ADDR_W-24){imm_24bit[23]}}, imm_24bit} << 1;
    assign taken   = is_branch && (rt_ra_equal ^ branch_ne);
    assign next_pc = is_jump ? pc + jmp_off : taken ? pc + br_off : pc + ADDR_W'(4);
    assign im_req  = state == FETCH;
    assign im_addr = pc;
    assign pc_out  = pc;
    assign link_pc = pc + ADDR_W'(4);
    // fetch FSM: request until ready, hold until retired, trap on a misaligned target
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instruction <= '0;
            inst_valid  <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            case (state)
                BOOT:  state <= FETCH;
                FETCH: if (im_ready) begin
                    instruction <= im_rdata;
                    inst_valid  <= 1'b1;
                    state       <= HOLD;
                end
                HOLD:  if (inst_accept) begin
                    inst_valid <= 1'b0;
                    if (next_pc[1:0] != 2'b00) begin
                        fetch_error <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a behavioural model
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_accept = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic        rt_ra_equal = 1'b0;
    logic        is_jump = 1'b0;
    logic [13:0] imm_14bit = '0;
    logic [23:0] imm_24bit = '0;
    logic [31:0] pc_out;
    logic [31:0] link_pc;
    logic        fetch_error;
    int n_checks = 0;
    int n_fail = 0;
    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .im_req(im_req), .im_addr(im_addr),
        .im_ready(im_ready), .im_rdata(im_rdata), .instruction(instruction),
        .inst_valid(inst_valid), .inst_accept(inst_accept), .is_branch(is_branch),
        .branch_ne(branch_ne), .rt_ra_equal(rt_ra_equal), .is_jump(is_jump),
        .imm_14bit(imm_14bit), .imm_24bit(imm_24bit), .pc_out(pc_out),
        .link_pc(link_pc), .fetch_error(fetch_error)
    );
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask
    // behavioural model: booting / erred / holding flags, the PC and the held word
    logic        m_boot, m_err, m_valid;
    logic [31:0] m_pc, m_instr;
    always @(posedge clock or posedge reset) begin
        logic signed [31:0] off;
        logic [31:0] t;
        if (reset) begin
            m_boot = 1; m_err = 0; m_valid = 0; m_pc = 32'h0; m_instr = 32'h0;
        end else if (m_boot) m_boot = 0;
        else if (m_err) begin end
        else if (!m_valid) begin
            if (im_ready) begin m_instr = im_rdata; m_valid = 1; end
        end else if (inst_accept) begin
            if (is_jump) off = $signed(imm_24bit);
            else if (is_branch && (rt_ra_equal != branch_ne)) off = $signed(imm_14bit);
            else off = 2;
            t = m_pc + 32'(off * 2);
            m_valid = 0;
            if (t % 4 != 0) m_err = 1;
            else m_pc = t;
        end
    end
    // per-cycle comparison of every output against the model
    always @(negedge clock) if (!reset) begin
        chk("im_req", {31'b0, im_req}, {31'b0, !(m_boot || m_err || m_valid)});
        chk("im_addr", im_addr, m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("instruction", instruction, m_instr);
        chk("pc_out", pc_out, m_pc);
        chk("link_pc", link_pc, m_pc + 32'd4);
        chk("fetch_error", {31'b0, fetch_error}, {31'b0, m_err});
    end
    task automatic step; @(negedge clock); endtask
    task automatic clear_fb;
        inst_accept = 0; is_jump = 0; is_branch = 0; branch_ne = 0; rt_ra_equal = 0;
        imm_14bit = '0; imm_24bit = '0;
    endtask
    task automatic do_reset(input bit mid);
        if (mid) begin @(posedge clock); #2 reset = 1; end
        else reset = 1;
        step; step;
        reset = 0;
    endtask
    task automatic fetch(input logic [31:0] d);
        int k = 0;
        while (!im_req && k < 20) begin step; k++; end
        chk("wait_req", {31'b0, im_req}, 32'd1);
        im_ready = 1; im_rdata = d;
        step;
        im_ready = 0; im_rdata = $urandom;
        chk("fetched_valid", {31'b0, inst_valid}, 32'd1);
        chk("fetched_word", instruction, d);
    endtask
    task automatic retire(input bit j, input bit b, input bit ne, input bit eq,
                          input logic [13:0] i14, input logic [23:0] i24);
        is_jump = j; is_branch = b; branch_ne = ne; rt_ra_equal = eq;
        imm_14bit = i14; imm_24bit = i24; inst_accept = 1;
        step;
        clear_fb;
    endtask
    initial begin
        int errc;
        step; step;
        chk("rst_req", {31'b0, im_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_error}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_addr", im_addr, 32'd0);
        im_ready = 1; im_rdata = 32'hA0; inst_accept = 1; reset = 0;
        step;
        chk("t1_addr0", im_addr, 32'h0);
        chk("t1_req0", {31'b0, im_req}, 32'd1);
        step;
        chk("t1_valid", {31'b0, inst_valid}, 32'd1);
        chk("t1_instr", instruction, 32'hA0);
        step;
        chk("t1_addr4", im_addr, 32'h4);
        chk("t1_novalid", {31'b0, inst_valid}, 32'd0);
        step; step;
        chk("t1_addr8", im_addr, 32'h8);
        im_ready = 0; inst_accept = 0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("t2_req", {31'b0, im_req}, 32'd1);
            chk("t2_addr", im_addr, 32'h8);
            chk("t2_novalid", {31'b0, inst_valid}, 32'd0);
        end
        fetch(32'h1234);
        retire(1, 0, 0, 0, 0, 24'h00000C);
        chk("t3_pc20", im_addr, 32'h20);
        fetch(32'h11);
        retire(0, 1, 0, 1, 14'h0010, 0);
        chk("t3_beq_taken", im_addr, 32'h40);
        fetch(32'h12);
        retire(1, 0, 0, 0, 0, 24'hFFFFF0);
        chk("t3_back20", im_addr, 32'h20);
        fetch(32'h13);
        retire(0, 1, 0, 0, 14'h0010, 0);
        chk("t3_beq_untaken", im_addr, 32'h24);
        fetch(32'h14);
        retire(1, 0, 0, 0, 0, 24'hFFFFFE);
        fetch(32'h15);
        retire(0, 1, 1, 0, 14'h0010, 0);
        chk("t3_bne_taken", im_addr, 32'h40);
        fetch(32'h16);
        retire(1, 0, 0, 0, 0, 24'h000060);
        fetch(32'h17);
        chk("t4_pc_out", pc_out, 32'h100);
        chk("t4_link", link_pc, 32'h104);
        retire(1, 0, 0, 0, 0, 24'hFFFFFE);
        chk("t4_jump_back", im_addr, 32'hFC);
        fetch(32'h18);
        retire(1, 0, 0, 0, 0, 24'hFFFF80);
        fetch(32'h19);
        chk("t6_top_pc", pc_out, 32'hFFFFFFFC);
        chk("t6_top_link", link_pc, 32'h0);
        retire(0, 0, 0, 0, 0, 0);
        chk("t6_wrap", im_addr, 32'h0);
        fetch(32'h1A);
        retire(0, 0, 0, 0, 0, 0);
        chk("t6_addr4", im_addr, 32'h4);
        #2 reset = 1;
        #1;
        chk("t6_async_req", {31'b0, im_req}, 32'd0);
        chk("t6_async_pc", pc_out, 32'h0);
        im_ready = 1; im_rdata = 32'hDEAD;
        step;
        im_ready = 0; reset = 0;
        chk("t6_late_ready", {31'b0, inst_valid}, 32'd0);
        fetch(32'h1B);
        retire(0, 1, 0, 1, 14'h0001, 0);
        chk("t5_err", {31'b0, fetch_error}, 32'd1);
        chk("t5_pc_kept", pc_out, 32'h0);
        im_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("t5_req_low", {31'b0, im_req}, 32'd0);
            chk("t5_valid_low", {31'b0, inst_valid}, 32'd0);
        end
        im_ready = 0;
        do_reset(0);
        chk("t5_err_cleared", {31'b0, fetch_error}, 32'd0);
        errc = 0;
        for (int i = 0; i < 5000; i++) begin
            step;
            im_ready = $urandom_range(1);
            im_rdata = $urandom;
            inst_accept = $urandom_range(1);
            is_jump = $urandom_range(7) == 0;
            is_branch = $urandom_range(3) == 0;
            branch_ne = $urandom_range(1);
            rt_ra_equal = $urandom_range(1);
            imm_14bit = 14'($urandom);
            imm_24bit = 24'($urandom);
            if ($urandom_range(15) != 0) begin imm_14bit[0] = 0; imm_24bit[0] = 0; end
            errc = m_err ? errc + 1 : 0;
            if (errc > 3 || $urandom_range(199) == 0) begin
                do_reset($urandom_range(1) == 1);
                errc = 0;
            end
        end
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
